// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
// Optional build macro used by spi_resp: SPI_RESP_MISO_TRI_EN.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_resp_state_t;

  localparam int SPI_WORD_W = 16;
  localparam int SPI_SYNC_STAGES = 2;
  // Shortest SCLK phase, in clk periods, the responder can follow.
  localparam int SPI_MIN_SCLK_HALF = SPI_SYNC_STAGES + 3;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous input plus
// rise/fall detection against one history flop.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_hist;
  assign o_fall = ~o_q & r_hist;

endmodule

// File: rtl/spi_resp.sv
// SPI mode-0 responder: oversampled SS_n/SCLK/MOSI, MSB-first frames.
// Define SPI_RESP_MISO_TRI_EN to float MISO while not busy.
module spi_resp
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WORD_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             wrt,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
  output logic             busy,
  output logic             frm_err
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  spi_resp_state_t r_state;
  spi_resp_state_t w_nxt;

  logic [WIDTH-1:0] r_tx_buf;
  logic [WIDTH-1:0] r_shft;
  logic [WIDTH-1:0] r_rx_data;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_mosi_smpl;
  logic             r_busy;
  logic             r_rdy;
  logic             r_frm_err;
  logic             r_miso;

  logic w_ss_q, w_ss_rise, w_ss_fall;
  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_mosi;
  logic w_load, w_done_ok, w_done_err, w_shifting;
  logic w_unused_sclk_q;

  logic [SYNC_STAGES-1:0] r_mosi_sync;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_ss_sync (
    .clk   (clk),
    .rst   (rst),
    .i_d   (SS_n),
    .o_q   (w_ss_q),
    .o_rise(w_ss_rise),
    .o_fall(w_ss_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .i_d   (SCLK),
    .o_q   (w_sclk_q),
    .o_rise(w_sclk_rise),
    .o_fall(w_sclk_fall)
  );

  assign w_unused_sclk_q = w_sclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // The SS_n rise cycle (sync'd SS_n high) ends shifting, so a
  // coincident trailing SCLK fall cannot disturb the frame.
  assign w_shifting = (r_state == SHIFT) && !w_ss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_load     = 1'b0;
    w_done_ok  = 1'b0;
    w_done_err = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_load = 1'b1;
          w_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          w_nxt = DONE;
        end
      end
      DONE: begin
        w_nxt = IDLE;
        if (r_bit_cnt == CNT_FULL) begin
          w_done_ok = 1'b1;
        end else begin
          w_done_err = 1'b1;
        end
      end
      default: begin
        w_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_buf    <= '0;
      r_shft      <= '0;
      r_rx_data   <= '0;
      r_bit_cnt   <= '0;
      r_mosi_smpl <= 1'b0;
      r_busy      <= 1'b0;
      r_rdy       <= 1'b0;
      r_frm_err   <= 1'b0;
      r_miso      <= 1'b0;
    end else begin
      if (wrt) begin
        r_tx_buf <= tx_data;
      end
      if (w_load) begin
        r_shft    <= wrt ? tx_data : r_tx_buf;
        r_bit_cnt <= '0;
        r_busy    <= 1'b1;
      end else if (w_shifting) begin
        if (w_sclk_rise) begin
          r_mosi_smpl <= w_mosi;
          if (r_bit_cnt != CNT_SAT) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        if (w_sclk_fall && (r_bit_cnt != '0)) begin
          r_shft <= {r_shft[WIDTH-2:0], r_mosi_smpl};
        end
      end
      // Last bit has no trailing SCLK fall; merge it here.
      if (w_done_ok) begin
        r_rx_data <= {r_shft[WIDTH-2:0], r_mosi_smpl};
      end
      if (r_state == DONE) begin
        r_busy <= 1'b0;
        r_shft <= '0;
      end
      r_rdy     <= w_done_ok;
      r_frm_err <= w_done_err;
      r_miso    <= r_busy & r_shft[WIDTH-1];
    end
  end

`ifdef SPI_RESP_MISO_TRI_EN
  logic r_miso_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miso_oe <= 1'b0;
    end else begin
      r_miso_oe <= r_busy;
    end
  end

  assign MISO = r_miso_oe ? r_miso : 1'bz;
`else
  assign MISO = r_miso;
`endif

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign busy    = r_busy;
  assign frm_err = r_frm_err;

endmodule
